multi_linebuffer: RTL

- Parametrised successor to the single line FIFO: holds NUM_LINES-1 full image lines in on-chip RAM.
- Presents NUM_LINES vertically aligned pixels (one column, consecutive rows) per accepted input pixel.
- Sits between the pixel source (camera/video timing) and window-based filters (3x3/5x5 Sobel, median, Gaussian).
- Adds a runtime line width, frame-start resynchronisation, priming status and end-of-line flagging.

---
 rtl/multi_linebuffer_if.sv | 24 ++
 rtl/multi_linebuffer.sv | 70 +++++++
 2 files changed

// File: rtl/multi_linebuffer_if.sv
// multi_linebuffer_if: pixel source side (cfg_width, in_valid/in_sof/in_data) and tap side (out_valid/out_taps/out_col/out_eol/out_primed)
interface multi_linebuffer_if #(
  parameter int DATA_W    = 24,
  parameter int NUM_LINES = 3,
  parameter int ADDR_W    = 11
);
  logic [ADDR_W-1:0]           cfg_width;
  logic                        in_valid;
  logic                        in_sof;
  logic [DATA_W-1:0]           in_data;
  logic                        out_valid;
  logic [DATA_W*NUM_LINES-1:0] out_taps;
  logic [ADDR_W-1:0]           out_col;
  logic                        out_eol;
  logic                        out_primed;
  modport master (
    output cfg_width, in_valid, in_sof, in_data,
    input  out_valid, out_taps, out_col, out_eol, out_primed
  );
  modport slave (
    input  cfg_width, in_valid, in_sof, in_data,
    output out_valid, out_taps, out_col, out_eol, out_primed
  );
endinterface

// File: rtl/multi_linebuffer.sv
// multi_linebuffer: stores NUM_LINES-1 lines and emits one column of NUM_LINES vertically aligned pixels per accepted pixel (clk, reset, s: pixel in / taps out)
module multi_linebuffer #(
  parameter int DATA_W    = 24,
  parameter int MAX_WIDTH = 1024,
  parameter int NUM_LINES = 3,
  parameter int ADDR_W    = 11
) (
  input logic clk,
  input logic reset,
  multi_linebuffer_if.slave s
);
  localparam int RAM_AW = $clog2(MAX_WIDTH);
  localparam int RW = $clog2(NUM_LINES);
  localparam logic [RW-1:0] FULL = RW'(NUM_LINES - 1);
  logic [ADDR_W-1:0] col, eff_width, w, cur_col, c1;
  logic [RW-1:0] rows_done, rd0;
  logic eol, acc, v1, e1, p1;
  logic [DATA_W-1:0] d1;
  logic [NUM_LINES-2:0][DATA_W-1:0] rdq;
  always_comb begin
    acc = s.in_valid;
    w = !s.in_sof ? eff_width :
        s.cfg_width < ADDR_W'(2) ? ADDR_W'(2) :
        s.cfg_width > ADDR_W'(MAX_WIDTH) ? ADDR_W'(MAX_WIDTH) : s.cfg_width;
    cur_col = s.in_sof ? '0 : col;
    rd0 = s.in_sof ? '0 : rows_done;
    eol = cur_col == w - ADDR_W'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      rows_done <= '0;
      eff_width <= ADDR_W'(MAX_WIDTH);
      v1 <= 1'b0;
      d1 <= '0;
      c1 <= '0;
      e1 <= 1'b0;
      p1 <= 1'b0;
    end else begin
      v1 <= acc;
      if (acc) begin
        eff_width <= w;
        col <= eol ? '0 : cur_col + ADDR_W'(1);
        rows_done <= (eol && rd0 != FULL) ? rd0 + RW'(1) : rd0;
        d1 <= s.in_data;
        c1 <= cur_col;
        e1 <= eol;
        p1 <= rd0 == FULL;
      end
    end
  end
  for (genvar k = 0; k < NUM_LINES - 1; k++) begin : g_line
    logic [DATA_W-1:0] mem [MAX_WIDTH];
    logic [DATA_W-1:0] wd;
    if (k == 0) begin : g_head
      assign wd = d1;
    end else begin : g_shift
      assign wd = rdq[k-1];
    end
    always_ff @(posedge clk)
      if (v1) mem[c1[RAM_AW-1:0]] <= wd;
    always_ff @(posedge clk)
      rdq[k] <= reset ? '0 : acc ? mem[cur_col[RAM_AW-1:0]] : rdq[k];
  end
  assign s.out_valid  = v1;
  assign s.out_taps   = {rdq, d1};
  assign s.out_col    = c1;
  assign s.out_eol    = e1;
  assign s.out_primed = p1;
endmodule
